// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze generator.
//   state_t   : generator FSM states
//   dir_t     : carve directions, E=0 S=1 W=2 N=3
//   cell_t    : per-cell storage {visited, east_open, south_open}
//   LFSR_POLY : Galois feedback mask of the 16-bit LFSR
//   pick_dir  : first candidate direction scanning upward (with wrap) from a start
//   lfsr_next : one Galois LFSR step
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_INIT  = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_S = 2'd1,
        DIR_W = 2'd2,
        DIR_N = 2'd3
    } dir_t;

    typedef struct packed {
        logic visited;
        logic east_open;
        logic south_open;
    } cell_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Walk from the farthest offset back to offset 0 so the nearest set bit
    // (starting at 'first' and wrapping) is the one left in d.
    function automatic dir_t pick_dir(input logic [3:0] mask, input logic [1:0] first);
        dir_t       d;
        logic [1:0] k;
        d = dir_t'(first);
        for (int i = 3; i >= 0; i--) begin
            k = first + 2'(i);
            if (mask[k]) begin
                d = dir_t'(k);
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Galois LFSR used as the maze's direction source.
//   clk, rst : clock and synchronous active-high reset (value -> 16'h0001)
//   load     : load seed (a zero seed is replaced by 16'h0001, the all-zero
//              state would lock the register)
//   seed     : value to load
//   advance  : step the register once
//   value    : current register contents
module maze_lfsr
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_r;

    // LFSR register: load has priority over advance
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= 16'h0001;
        end else if (load) begin
            value_r <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (advance) begin
            value_r <= lfsr_next(value_r);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/maze_gen.sv
// Depth-first (recursive backtracker) maze generator.
// A start pulse clears the grid one cell per cycle, seeds the walk at (0,0)
// and then carves or backtracks one step per cycle until the stack empties.
//   clk, rst   : clock, synchronous active-high reset
//   start/seed : request a new maze; accepted only in IDLE or DONE
//   busy       : high for exactly 3*MAZE_W*MAZE_H cycles per maze
//   done       : maze valid; held until the next accepted start or rst
//   rd_x/rd_y  : read-port cell coordinates
//   rd_data    : {south_open, east_open} of the addressed cell, one cycle later
module maze_gen
    import maze_pkg::*;
#(
    parameter int  MAZE_W = 16,
    parameter int  MAZE_H = 8,
    localparam int XW     = $clog2(MAZE_W),
    localparam int YW     = $clog2(MAZE_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   seed,
    output logic          busy,
    output logic          done,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic [1:0]    rd_data
);

    localparam int NCELL = MAZE_W * MAZE_H;
    localparam int IW    = $clog2(NCELL);
    localparam int SPW   = $clog2(NCELL + 1);
    localparam int SEW   = XW + YW;

    function automatic logic [IW-1:0] cell_idx(input int x, input int y);
        return IW'(x + y * MAZE_W);
    endfunction

    state_t          state_r, state_s;
    logic [XW-1:0]   cur_x_r, nb_x_s;
    logic [YW-1:0]   cur_y_r, nb_y_s;
    logic [SPW-1:0]  sp_r;
    logic [IW-1:0]   clr_idx_r;
    logic            busy_r, done_r;
    logic [1:0]      rd_data_r;

    logic [SEW-1:0]  stack_r [NCELL];
    cell_t           cells_r [NCELL];

    logic [IW-1:0]   cur_idx_s, e_idx_s, s_idx_s, w_idx_s, n_idx_s, nb_idx_s, rd_idx_s;
    logic            e_in_s, s_in_s, w_in_s, n_in_s;
    logic [3:0]      mask_s;
    dir_t            dir_s;
    logic            accept_s, carve_s, last_pop_s;
    logic [SEW-1:0]  pop_top_s;
    logic [1:0]      lfsr_low_s;
    logic [13:0]     lfsr_unused_s;

    // Only the two low LFSR bits steer the walk; the rest live on inside the LFSR.
    maze_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .seed    (seed),
        .advance (state_r == ST_STEP),
        .value   ({lfsr_unused_s, lfsr_low_s})
    );

    // Neighbour addresses, candidate mask, chosen direction and carve target.
    // Out-of-grid neighbours alias the current cell; their mask bit is forced 0.
    always_comb begin
        cur_idx_s  = cell_idx(int'(cur_x_r), int'(cur_y_r));
        e_in_s     = (int'(cur_x_r) < MAZE_W - 1);
        s_in_s     = (int'(cur_y_r) < MAZE_H - 1);
        w_in_s     = (cur_x_r != {XW{1'b0}});
        n_in_s     = (cur_y_r != {YW{1'b0}});
        e_idx_s    = e_in_s ? cell_idx(int'(cur_x_r) + 1, int'(cur_y_r)) : cur_idx_s;
        s_idx_s    = s_in_s ? cell_idx(int'(cur_x_r), int'(cur_y_r) + 1) : cur_idx_s;
        w_idx_s    = w_in_s ? cell_idx(int'(cur_x_r) - 1, int'(cur_y_r)) : cur_idx_s;
        n_idx_s    = n_in_s ? cell_idx(int'(cur_x_r), int'(cur_y_r) - 1) : cur_idx_s;
        mask_s[0]  = e_in_s && !cells_r[e_idx_s].visited;
        mask_s[1]  = s_in_s && !cells_r[s_idx_s].visited;
        mask_s[2]  = w_in_s && !cells_r[w_idx_s].visited;
        mask_s[3]  = n_in_s && !cells_r[n_idx_s].visited;
        dir_s      = pick_dir(mask_s, lfsr_low_s);
        carve_s    = (mask_s != 4'b0000);
        last_pop_s = !carve_s && (sp_r == SPW'(1));
        pop_top_s  = stack_r[IW'(sp_r - SPW'(2))];
        rd_idx_s   = cell_idx(int'(rd_x), int'(rd_y));
        nb_x_s     = cur_x_r;
        nb_y_s     = cur_y_r;
        nb_idx_s   = cur_idx_s;
        case (dir_s)
            DIR_E: begin
                nb_x_s   = cur_x_r + XW'(1'b1);
                nb_idx_s = e_idx_s;
            end
            DIR_S: begin
                nb_y_s   = cur_y_r + YW'(1'b1);
                nb_idx_s = s_idx_s;
            end
            DIR_W: begin
                nb_x_s   = cur_x_r - XW'(1'b1);
                nb_idx_s = w_idx_s;
            end
            DIR_N: begin
                nb_y_s   = cur_y_r - YW'(1'b1);
                nb_idx_s = n_idx_s;
            end
            default: begin
                nb_idx_s = cur_idx_s;
            end
        endcase
    end

    // Next-state logic and start acceptance
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_CLEAR;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_r == IW'(NCELL - 1)) begin
                    state_s = ST_INIT;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_INIT: begin
                state_s = ST_STEP;
            end
            ST_STEP: begin
                if (last_pop_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STEP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, walk position, stack pointer, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cur_x_r   <= {XW{1'b0}};
            cur_y_r   <= {YW{1'b0}};
            sp_r      <= {SPW{1'b0}};
            clr_idx_r <= {IW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        clr_idx_r <= {IW{1'b0}};
                    end else begin
                        busy_r    <= busy_r;
                    end
                end
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + IW'(1'b1);
                end
                ST_INIT: begin
                    cur_x_r <= {XW{1'b0}};
                    cur_y_r <= {YW{1'b0}};
                    sp_r    <= SPW'(1'b1);
                end
                ST_STEP: begin
                    if (carve_s) begin
                        cur_x_r <= nb_x_s;
                        cur_y_r <= nb_y_s;
                        sp_r    <= sp_r + SPW'(1'b1);
                    end else if (last_pop_s) begin
                        sp_r    <= {SPW{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        // backtrack: the entry below the popped one becomes current
                        sp_r    <= sp_r - SPW'(1'b1);
                        cur_x_r <= pop_top_s[SEW-1:YW];
                        cur_y_r <= pop_top_s[YW-1:0];
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Grid and stack storage: no reset, CLEAR defines every cell before carving.
    // A freshly visited neighbour is always all-zero, so it is written whole.
    always_ff @(posedge clk) begin
        case (state_r)
            ST_CLEAR: begin
                cells_r[clr_idx_r] <= '{visited: 1'b0, east_open: 1'b0, south_open: 1'b0};
            end
            ST_INIT: begin
                cells_r[{IW{1'b0}}] <= '{visited: 1'b1, east_open: 1'b0, south_open: 1'b0};
                stack_r[{IW{1'b0}}] <= {SEW{1'b0}};
            end
            ST_STEP: begin
                if (carve_s) begin
                    cells_r[nb_idx_s] <= '{visited:    1'b1,
                                           east_open:  (dir_s == DIR_W),
                                           south_open: (dir_s == DIR_N)};
                    stack_r[IW'(sp_r)] <= {nb_x_s, nb_y_s};
                    if (dir_s == DIR_E) begin
                        cells_r[cur_idx_s].east_open <= 1'b1;
                    end else if (dir_s == DIR_S) begin
                        cells_r[cur_idx_s].south_open <= 1'b1;
                    end else begin
                        cells_r[cur_idx_s].visited <= 1'b1;
                    end
                end else begin
                    stack_r[{IW{1'b0}}] <= stack_r[{IW{1'b0}}];
                end
            end
            default: begin
                stack_r[{IW{1'b0}}] <= stack_r[{IW{1'b0}}];
            end
        endcase
    end

    // Registered read port, live in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 2'b00;
        end else begin
            rd_data_r <= {cells_r[rd_idx_s].south_open, cells_r[rd_idx_s].east_open};
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_data = rd_data_r;

endmodule

// File: tb/tb_maze_gen.sv
// Directed bench for maze_gen: a 16x8 instance and a 2x2 instance whose
// mazes are hand-traced from the LFSR sequence.
module tb_maze_gen;

    logic        clk = 1'b0;
    logic        rst, start, s_start;
    logic [15:0] seed, s_seed;
    logic        busy, done, s_busy, s_done;
    logic [3:0]  rd_x;
    logic [2:0]  rd_y;
    logic        s_rd_x, s_rd_y;
    logic [1:0]  rd_data, s_rd_data;

    int errors = 0;
    int checks = 0;

    logic [1:0] grid_tmp [128];
    logic [1:0] grid_ace [128];
    logic [1:0] grid_z   [128];

    always #5 clk = ~clk;

    maze_gen #(.MAZE_W(16), .MAZE_H(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy), .done(done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
    );

    maze_gen #(.MAZE_W(2), .MAZE_H(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .seed(s_seed), .busy(s_busy), .done(s_done),
        .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_data(s_rd_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the 16x8 instance and count busy cycles; optionally
    // re-pulse start or assert rst at a given busy cycle.
    task automatic run_big(input logic [15:0] sd, input int restart_at, input int rst_at,
                           output int busy_cycles, output bit aborted);
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        seed  = 16'h0000;
        busy_cycles = 0;
        aborted = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_cleared_on_start: got %b want 0", done);
        end
        for (int c = 0; c < 2000; c++) begin
            if (busy !== 1'b1) break;
            busy_cycles++;
            if (busy_cycles == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (busy_cycles == restart_at) begin
                start = 1'b1;
                seed  = 16'h1234;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic readout_big;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                rd_x = 4'(x);
                rd_y = 3'(y);
                tick();
                grid_tmp[y * 16 + x] = rd_data;
            end
        end
    endtask

    // Structural checks on grid_tmp: wall count, boundaries, connectivity.
    task automatic check_maze_big(input string name);
        int  walls, reached, bad_east, bad_south;
        bit  reach [128];
        walls = 0; bad_east = 0; bad_south = 0; reached = 0;
        for (int i = 0; i < 128; i++) begin
            walls += int'(grid_tmp[i][0]) + int'(grid_tmp[i][1]);
            if (i % 16 == 15 && grid_tmp[i][0]) bad_east++;
            if (i / 16 == 7 && grid_tmp[i][1]) bad_south++;
            reach[i] = (i == 0);
        end
        repeat (128) begin
            for (int i = 0; i < 128; i++) begin
                if (grid_tmp[i][0] && (i % 16 != 15) && (reach[i] || reach[i + 1])) begin
                    reach[i] = 1'b1;
                    reach[i + 1] = 1'b1;
                end
                if (grid_tmp[i][1] && (i / 16 != 7) && (reach[i] || reach[i + 16])) begin
                    reach[i] = 1'b1;
                    reach[i + 16] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 128; i++) reached += int'(reach[i]);
        checks++;
        if (walls != 127) begin
            errors++;
            $display("FAIL %s_open_walls: got %0d want 127", name, walls);
        end
        checks++;
        if (bad_east != 0 || bad_south != 0) begin
            errors++;
            $display("FAIL %s_boundary: got east=%0d south=%0d open edge walls want 0", name, bad_east, bad_south);
        end
        checks++;
        if (reached != 128) begin
            errors++;
            $display("FAIL %s_connected: got %0d reachable want 128", name, reached);
        end
    endtask

    task automatic check_run_end(input string name, input int cycles);
        checks++;
        if (cycles != 384) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d want 384", name, cycles);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_edge: got done=%b busy=%b want done=1 busy=0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; s_start = 1'b0; seed = 16'h0000; s_seed = 16'h0000;
        rd_x = 4'd0; rd_y = 3'd0; s_rd_x = 1'b0; s_rd_y = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, rd_data} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_big: got busy=%b done=%b rd_data=%b want 0", busy, done, rd_data);
        end
        checks++;
        if ({s_busy, s_done, s_rd_data} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_small: got busy=%b done=%b rd_data=%b want 0", s_busy, s_done, s_rd_data);
        end
    endtask

    // 2x2 mazes traced by hand. seed 1: S from (0,0), E, N, backtrack.
    // seed 2: E (wrap from W), S, W, backtrack. Read-out is {south,east}.
    task automatic test_small;
        logic [15:0] seeds [2];
        logic [1:0]  expv  [2][4];
        int          cnt, walls;
        seeds[0] = 16'h0001;
        seeds[1] = 16'h0002;
        expv[0][0] = 2'b10; expv[0][1] = 2'b10; expv[0][2] = 2'b01; expv[0][3] = 2'b00;
        expv[1][0] = 2'b01; expv[1][1] = 2'b10; expv[1][2] = 2'b01; expv[1][3] = 2'b00;
        for (int t = 0; t < 2; t++) begin
            s_seed  = seeds[t];
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            cnt = 0;
            for (int c = 0; c < 100; c++) begin
                if (s_busy !== 1'b1) break;
                if (s_done !== 1'b0) cnt = -1000;
                cnt++;
                tick();
            end
            checks++;
            if (cnt != 12) begin
                errors++;
                $display("FAIL small_busy_cycles: seed %h got %0d want 12", seeds[t], cnt);
            end
            checks++;
            if (s_done !== 1'b1) begin
                errors++;
                $display("FAIL small_done_edge: seed %h got %b want 1", seeds[t], s_done);
            end
            walls = 0;
            for (int i = 0; i < 4; i++) begin
                s_rd_x = i[0];
                s_rd_y = i[1];
                tick();
                walls += int'(s_rd_data[0]) + int'(s_rd_data[1]);
                checks++;
                if (s_rd_data !== expv[t][i]) begin
                    errors++;
                    $display("FAIL small_cell: seed %h cell %0d got %b want %b", seeds[t], i, s_rd_data, expv[t][i]);
                end
            end
            checks++;
            if (walls != 3) begin
                errors++;
                $display("FAIL small_open_walls: seed %h got %0d want 3", seeds[t], walls);
            end
        end
    endtask

    task automatic test_basic;
        int cyc; bit ab;
        run_big(16'hACE1, 0, 0, cyc, ab);
        check_run_end("ace1", cyc);
        repeat (5) tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_held: got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        readout_big();
        grid_ace = grid_tmp;
        check_maze_big("ace1");
    endtask

    task automatic test_repeat_seed;
        int cyc; bit ab; int diff;
        run_big(16'hACE1, 0, 0, cyc, ab);
        check_run_end("ace1_again", cyc);
        readout_big();
        diff = 0;
        for (int i = 0; i < 128; i++) if (grid_tmp[i] !== grid_ace[i]) diff++;
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL repeat_seed_identical: got %0d differing cells want 0", diff);
        end
    endtask

    task automatic test_seed_zero;
        int cyc; bit ab; int diff;
        run_big(16'h0000, 0, 0, cyc, ab);
        check_run_end("seed0", cyc);
        readout_big();
        grid_z = grid_tmp;
        check_maze_big("seed0");
        run_big(16'h0001, 0, 0, cyc, ab);
        check_run_end("seed1", cyc);
        readout_big();
        diff = 0;
        for (int i = 0; i < 128; i++) if (grid_tmp[i] !== grid_z[i]) diff++;
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL seed0_equals_seed1: got %0d differing cells want 0", diff);
        end
    endtask

    task automatic test_restart_ignored;
        int cyc; bit ab; int diff;
        run_big(16'hACE1, 20, 0, cyc, ab);
        check_run_end("restart", cyc);
        readout_big();
        diff = 0;
        for (int i = 0; i < 128; i++) if (grid_tmp[i] !== grid_ace[i]) diff++;
        checks++;
        if (diff != 0) begin
            errors++;
            $display("FAIL restart_ignored_grid: got %0d differing cells want 0", diff);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit ab;
        run_big(16'hACE1, 0, 50, cyc, ab);
        checks++;
        if (ab !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_data !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: got aborted=%b busy=%b done=%b rd_data=%b want 1 0 0 00",
                     ab, busy, done, rd_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stays_idle: got busy=%b want 0", busy);
        end
        run_big(16'h5A5A, 0, 0, cyc, ab);
        check_run_end("after_reset", cyc);
        readout_big();
        check_maze_big("after_reset");
    endtask

    initial begin
        test_reset();
        test_small();
        test_basic();
        test_repeat_seed();
        test_seed_zero();
        test_restart_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
